// File: rtl/asteroides_pkg.sv
// Shared definitions for the asteroid movement control unit: FSM state
// codes, direction codes and the layout of a table entry word.
// Entry word, MSB first: {ativo[1], dir[3], x[COORD_W], y[COORD_W]}.
package asteroides_pkg;

    localparam logic [2:0] ESTADO_OCIOSO  = 3'd0;
    localparam logic [2:0] ESTADO_LE      = 3'd1;
    localparam logic [2:0] ESTADO_AVALIA  = 3'd2;
    localparam logic [2:0] ESTADO_ESCREVE = 3'd3;
    localparam logic [2:0] ESTADO_FIM     = 3'd4;
    localparam logic [2:0] ESTADO_ILEGAL  = 3'd7;

    localparam logic [2:0] DIR_N  = 3'd0;
    localparam logic [2:0] DIR_NE = 3'd1;
    localparam logic [2:0] DIR_E  = 3'd2;
    localparam logic [2:0] DIR_SE = 3'd3;
    localparam logic [2:0] DIR_S  = 3'd4;
    localparam logic [2:0] DIR_SW = 3'd5;
    localparam logic [2:0] DIR_W  = 3'd6;
    localparam logic [2:0] DIR_NW = 3'd7;

    localparam int ATIVO_W = 1;
    localparam int DIR_LARG = 3;

    function automatic int entry_width(input int coord_w);
        return ATIVO_W + DIR_LARG + 2 * coord_w;
    endfunction

    function automatic int pos_y(input int coord_w);
        return 0 * coord_w;
    endfunction

    function automatic int pos_x(input int coord_w);
        return coord_w;
    endfunction

    function automatic int pos_dir(input int coord_w);
        return 2 * coord_w;
    endfunction

    function automatic int pos_ativo(input int coord_w);
        return 2 * coord_w + DIR_LARG;
    endfunction

endpackage

// File: rtl/uc_movimenta_asteroides_if.sv
// Asteroid RAM port bundle. The control unit is the master (drives the
// address, write enable and write data); the RAM is the slave and returns
// read data one cycle after the address is presented.
interface uc_movimenta_asteroides_if #(
    parameter int ADDR_W  = 4,
    parameter int COORD_W = 4
);
    import asteroides_pkg::*;

    localparam int W = entry_width(COORD_W);

    logic [ADDR_W-1:0] mem_endereco;
    logic              mem_escreve;
    logic [W-1:0]      mem_dado_escrito;
    logic [W-1:0]      mem_dado_lido;

    modport master (
        output mem_endereco,
        output mem_escreve,
        output mem_dado_escrito,
        input  mem_dado_lido
    );

    modport slave (
        input  mem_endereco,
        input  mem_escreve,
        input  mem_dado_escrito,
        output mem_dado_lido
    );

endinterface

// File: rtl/calc_posicao_asteroide.sv
// Combinational next-position calculator for one asteroid entry.
// Optional feature: ASTEROIDES_WRAP_EN -- when defined, a border crossing
// wraps around the grid and the asteroid stays active; otherwise the entry
// is deactivated with its coordinates left as they were.
module calc_posicao_asteroide
    import asteroides_pkg::*;
#(
    parameter int COORD_W = 4,
    localparam int W = entry_width(COORD_W)
) (
    input  logic [W-1:0] entrada,
    output logic [W-1:0] saida,
    output logic         cruzou_borda
);

    localparam int P_Y     = pos_y(COORD_W);
    localparam int P_X     = pos_x(COORD_W);
    localparam int P_DIR   = pos_dir(COORD_W);
    localparam int P_ATIVO = pos_ativo(COORD_W);

    logic               ativo;
    logic [2:0]         dir;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               mais_x;
    logic               menos_x;
    logic               mais_y;
    logic               menos_y;
    logic [COORD_W:0]   x_calc;
    logic [COORD_W:0]   y_calc;

    assign ativo = entrada[P_ATIVO];
    assign dir   = entrada[P_DIR +: DIR_LARG];
    assign x     = entrada[P_X +: COORD_W];
    assign y     = entrada[P_Y +: COORD_W];

    // Direction decode: which axis moves and which way for each compass code
    always_comb begin
        mais_x  = 1'b0;
        menos_x = 1'b0;
        mais_y  = 1'b0;
        menos_y = 1'b0;
        case (dir)
            DIR_N:  menos_y = 1'b1;
            DIR_NE: begin mais_x = 1'b1;  menos_y = 1'b1; end
            DIR_E:  mais_x = 1'b1;
            DIR_SE: begin mais_x = 1'b1;  mais_y = 1'b1; end
            DIR_S:  mais_y = 1'b1;
            DIR_SW: begin menos_x = 1'b1; mais_y = 1'b1; end
            DIR_W:  menos_x = 1'b1;
            DIR_NW: begin menos_x = 1'b1; menos_y = 1'b1; end
            default: ;
        endcase
    end

    // One-bit-wider step: the extra MSB flags both overflow past the top and underflow below zero
    always_comb begin
        x_calc = {1'b0, x};
        y_calc = {1'b0, y};
        if (mais_x)  x_calc = x_calc + (COORD_W+1)'(1);
        if (menos_x) x_calc = x_calc - (COORD_W+1)'(1);
        if (mais_y)  y_calc = y_calc + (COORD_W+1)'(1);
        if (menos_y) y_calc = y_calc - (COORD_W+1)'(1);
    end

    assign cruzou_borda = x_calc[COORD_W] | y_calc[COORD_W];

    // Build the written-back entry; direction is always preserved
    always_comb begin
`ifdef ASTEROIDES_WRAP_EN
        saida = {ativo, dir, x_calc[COORD_W-1:0], y_calc[COORD_W-1:0]};
`else
        if (cruzou_borda)
            saida = {1'b0, dir, x, y};
        else
            saida = {ativo, dir, x_calc[COORD_W-1:0], y_calc[COORD_W-1:0]};
`endif
    end

endmodule

// File: rtl/uc_movimenta_asteroides.sv
// Asteroid movement control unit: on each start pulse walks all table slots,
// reading each entry and writing back active asteroids moved one step.
// Optional feature: ASTEROIDES_WRAP_EN -- wrap at the border instead of
// deactivating; the asteroide_saiu port exists only when it is undefined.
module uc_movimenta_asteroides
    import asteroides_pkg::*;
#(
    parameter int N_ASTEROIDES = 16,
    parameter int ADDR_W       = 4,
    parameter int COORD_W      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sinal_movimenta_asteroides,
    uc_movimenta_asteroides_if.master mem,
    output logic       ocupado,
    output logic       fim_move_asteroides,
    output logic [2:0] db_estado_movimenta_asteroides
`ifndef ASTEROIDES_WRAP_EN
    ,
    output logic       asteroide_saiu
`endif
);

    localparam int W       = entry_width(COORD_W);
    localparam int P_ATIVO = pos_ativo(COORD_W);
    localparam logic [ADDR_W-1:0] IDX_ULTIMO = ADDR_W'(N_ASTEROIDES - 1);

    logic [2:0]        estado;
    logic [2:0]        estado_prox;
    logic [ADDR_W-1:0] idx;
    logic [W-1:0]      entrada;
    logic [W-1:0]      entrada_nova;
    logic              cruzou_borda;

    calc_posicao_asteroide #(
        .COORD_W (COORD_W)
    ) u_calc (
        .entrada      (entrada),
        .saida        (entrada_nova),
        .cruzou_borda (cruzou_borda)
    );

    // Next-state decision; AVALIA looks at the RAM data arriving this cycle
    always_comb begin
        estado_prox = ESTADO_OCIOSO;
        case (estado)
            ESTADO_OCIOSO:  estado_prox = sinal_movimenta_asteroides ? ESTADO_LE : ESTADO_OCIOSO;
            ESTADO_LE:      estado_prox = ESTADO_AVALIA;
            ESTADO_AVALIA: begin
                if (mem.mem_dado_lido[P_ATIVO])
                    estado_prox = ESTADO_ESCREVE;
                else if (idx == IDX_ULTIMO)
                    estado_prox = ESTADO_FIM;
                else
                    estado_prox = ESTADO_LE;
            end
            ESTADO_ESCREVE: estado_prox = (idx == IDX_ULTIMO) ? ESTADO_FIM : ESTADO_LE;
            ESTADO_FIM:     estado_prox = ESTADO_OCIOSO;
            default:        estado_prox = ESTADO_OCIOSO;
        endcase
    end

    // State, slot index and captured entry registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado  <= ESTADO_OCIOSO;
            idx     <= '0;
            entrada <= '0;
        end else begin
            estado <= estado_prox;
            case (estado)
                ESTADO_AVALIA: begin
                    entrada <= mem.mem_dado_lido;
                    if (!mem.mem_dado_lido[P_ATIVO] && idx != IDX_ULTIMO)
                        idx <= idx + ADDR_W'(1);
                end
                ESTADO_ESCREVE: begin
                    if (idx != IDX_ULTIMO)
                        idx <= idx + ADDR_W'(1);
                end
                ESTADO_LE: ;
                default: idx <= '0;
            endcase
        end
    end

    // Moore output decode from state and index only
    always_comb begin
        mem.mem_endereco     = '0;
        mem.mem_escreve      = 1'b0;
        mem.mem_dado_escrito = '0;
        fim_move_asteroides  = 1'b0;
        ocupado              = (estado != ESTADO_OCIOSO);
        db_estado_movimenta_asteroides = ESTADO_ILEGAL;
        case (estado)
            ESTADO_OCIOSO: db_estado_movimenta_asteroides = ESTADO_OCIOSO;
            ESTADO_LE: begin
                db_estado_movimenta_asteroides = ESTADO_LE;
                mem.mem_endereco = idx;
            end
            ESTADO_AVALIA: begin
                db_estado_movimenta_asteroides = ESTADO_AVALIA;
                mem.mem_endereco = idx;
            end
            ESTADO_ESCREVE: begin
                db_estado_movimenta_asteroides = ESTADO_ESCREVE;
                mem.mem_endereco     = idx;
                mem.mem_escreve      = 1'b1;
                mem.mem_dado_escrito = entrada_nova;
            end
            ESTADO_FIM: begin
                db_estado_movimenta_asteroides = ESTADO_FIM;
                fim_move_asteroides = 1'b1;
            end
            default: ;
        endcase
    end

`ifndef ASTEROIDES_WRAP_EN
    // Border-exit pulse coincides with the write that deactivates the entry
    assign asteroide_saiu = (estado == ESTADO_ESCREVE) && cruzou_borda;
`endif

endmodule

// File: tb/tb_uc_movimenta_asteroides.sv
// Self-checking bench for uc_movimenta_asteroides: a behavioural RAM, a
// timeline/arithmetic reference model, directed cases and random tables.
// Honours ASTEROIDES_WRAP_EN the same way as the design.
module tb_uc_movimenta_asteroides;

    localparam int N  = 16;
    localparam int CW = 4;
    localparam int W  = 12;

    logic       clock;
    logic       reset;
    logic       sinal_movimenta_asteroides;
    logic       ocupado;
    logic       fim_move_asteroides;
    logic [2:0] db_estado_movimenta_asteroides;
    logic       asteroide_saiu;

    uc_movimenta_asteroides_if #(.ADDR_W(4), .COORD_W(CW)) mem_if ();

    uc_movimenta_asteroides #(
        .N_ASTEROIDES (N),
        .ADDR_W       (4),
        .COORD_W      (CW)
    ) dut (
        .clock                          (clock),
        .reset                          (reset),
        .sinal_movimenta_asteroides     (sinal_movimenta_asteroides),
        .mem                            (mem_if),
        .ocupado                        (ocupado),
        .fim_move_asteroides            (fim_move_asteroides),
        .db_estado_movimenta_asteroides (db_estado_movimenta_asteroides)
`ifndef ASTEROIDES_WRAP_EN
        ,
        .asteroide_saiu                 (asteroide_saiu)
`endif
    );

`ifdef ASTEROIDES_WRAP_EN
    assign asteroide_saiu = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural synchronous RAM with a bench-side load port
    logic [W-1:0] ram [N];
    logic         load_en;
    logic [3:0]   load_addr;
    logic [W-1:0] load_data;

    always @(posedge clock) begin
        if (load_en)
            ram[load_addr] <= load_data;
        else if (mem_if.mem_escreve)
            ram[mem_if.mem_endereco] <= mem_if.mem_dado_escrito;
        mem_if.mem_dado_lido <= ram[mem_if.mem_endereco];
    end

    int n_checks;
    int n_fail;

    int dx_tab [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int dy_tab [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

    logic [W-1:0] tbl     [N];
    logic [W-1:0] snap    [N];
    logic [W-1:0] exp_new [N];
    int           wcyc    [N];
    bit           cr      [N];

    int last_fim;
    int last_fall;
    int last_writes;
    int last_fims;
    int last_saiu;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference rule: one grid step, then border handling
    function automatic logic [W-1:0] mover(input logic [W-1:0] e, output bit saiu);
        int x, y, d, nx, ny;
        bit fora;
        logic [W-1:0] r;
        x  = int'(e[7:4]);
        y  = int'(e[3:0]);
        d  = int'(e[10:8]);
        nx = x + dx_tab[d];
        ny = y + dy_tab[d];
        fora = (nx < 0) || (nx > 15) || (ny < 0) || (ny > 15);
        saiu = 1'b0;
`ifdef ASTEROIDES_WRAP_EN
        nx = (nx + 16) % 16;
        ny = (ny + 16) % 16;
        r = {1'b1, e[10:8], nx[3:0], ny[3:0]};
`else
        if (fora) begin
            saiu = 1'b1;
            r = {1'b0, e[10:0]};
        end else begin
            r = {1'b1, e[10:8], nx[3:0], ny[3:0]};
        end
`endif
        return r;
    endfunction

    task automatic loadTable();
        for (int i = 0; i < N; i++) begin
            @(negedge clock);
            load_en   = 1'b1;
            load_addr = 4'(i);
            load_data = tbl[i];
        end
        @(negedge clock);
        load_en = 1'b0;
        @(negedge clock);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ocupado"}, 32'(ocupado), 0);
        checkOutput({tag, "_fim"}, 32'(fim_move_asteroides), 0);
        checkOutput({tag, "_estado"}, 32'(db_estado_movimenta_asteroides), 0);
        checkOutput({tag, "_endereco"}, 32'(mem_if.mem_endereco), 0);
        checkOutput({tag, "_escreve"}, 32'(mem_if.mem_escreve), 0);
        checkOutput({tag, "_dado"}, 32'(mem_if.mem_dado_escrito), 0);
        checkOutput({tag, "_saiu"}, 32'(asteroide_saiu), 0);
    endtask

    // One walk: pulse start, watch every cycle, compare against the timeline model
    task automatic applyStimulus(input string tag, input int extra_at, input int reset_at);
        int t, na, nsaiu_exp, ociosos;
        bit done;
        t = 1; na = 0; nsaiu_exp = 0;
        for (int i = 0; i < N; i++) begin
            snap[i] = ram[i];
            if (snap[i][11]) begin
                exp_new[i] = mover(snap[i], cr[i]);
                wcyc[i] = t + 2;
                t += 3;
                na++;
                if (cr[i]) nsaiu_exp++;
            end else begin
                exp_new[i] = snap[i];
                cr[i] = 1'b0;
                wcyc[i] = 0;
                t += 2;
            end
        end
        last_fim = 0; last_fall = 0; last_writes = 0; last_fims = 0; last_saiu = 0;
        ociosos = 0; done = 1'b0;
        @(negedge clock);
        sinal_movimenta_asteroides = 1'b1;
        @(negedge clock);
        for (int c = 1; c <= 150; c++) begin
            sinal_movimenta_asteroides = (c == extra_at);
            if (c == reset_at) begin
                reset = 1'b1;
                #1;
                checkResetOutputs({tag, "_rst"});
                done = 1'b1;
                break;
            end
            if (mem_if.mem_escreve) begin
                last_writes++;
                checkOutput({tag, "_wr_dado"}, 32'(mem_if.mem_dado_escrito), 32'(exp_new[mem_if.mem_endereco]));
                checkOutput({tag, "_wr_ciclo"}, 32'(c), 32'(wcyc[mem_if.mem_endereco]));
`ifndef ASTEROIDES_WRAP_EN
                checkOutput({tag, "_wr_saiu"}, 32'(asteroide_saiu), 32'(cr[mem_if.mem_endereco]));
`endif
            end
            if (asteroide_saiu) last_saiu++;
            if (fim_move_asteroides) begin
                last_fims++;
                if (last_fim == 0) last_fim = c;
            end
            if (last_fim == 0 && !ocupado) ociosos++;
            if (last_fim != 0 && c > last_fim && !ocupado && last_fall == 0) last_fall = c;
            if (last_fim != 0 && c == last_fim + 3) begin
                done = 1'b1;
                break;
            end
            @(negedge clock);
        end
        sinal_movimenta_asteroides = 1'b0;
        checkOutput({tag, "_terminou"}, 32'(done), 1);
        if (reset_at != 0) begin
            checkOutput({tag, "_sem_fim"}, 32'(last_fims), 0);
            @(negedge clock);
            reset = 1'b0;
            @(negedge clock);
            for (int i = 0; i < N; i++)
                checkOutput({tag, "_ram"}, 32'(ram[i]),
                            (wcyc[i] != 0 && wcyc[i] < reset_at) ? 32'(exp_new[i]) : 32'(snap[i]));
        end else begin
            checkOutput({tag, "_fim_ciclo"}, 32'(last_fim), 32'(t));
            checkOutput({tag, "_fim_pulsos"}, 32'(last_fims), 1);
            checkOutput({tag, "_queda"}, 32'(last_fall), 32'(t + 1));
            checkOutput({tag, "_ocupado_na_volta"}, 32'(ociosos), 0);
            checkOutput({tag, "_escritas"}, 32'(last_writes), 32'(na));
            checkOutput({tag, "_saiu_total"}, 32'(last_saiu), 32'(nsaiu_exp));
            checkOutput({tag, "_estado_final"}, 32'(db_estado_movimenta_asteroides), 0);
            @(negedge clock);
            for (int i = 0; i < N; i++)
                checkOutput({tag, "_ram"}, 32'(ram[i]), 32'(exp_new[i]));
        end
    endtask

    task automatic fillAllSouth();
        for (int i = 0; i < N; i++)
            tbl[i] = {1'b1, 3'd4, 4'(i), 4'd0};
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        sinal_movimenta_asteroides = 1'b0;
        load_en = 1'b0;
        load_addr = '0;
        load_data = '0;
        #2;
        checkResetOutputs("reset_inicial");
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] single active slot");
        for (int i = 0; i < N; i++) tbl[i] = '0;
        tbl[3] = 12'hA57;
        loadTable();
        applyStimulus("slot3", 0, 0);
        checkOutput("slot3_valor", 32'(ram[3]), 32'h0A67);
        checkOutput("slot3_fim", 32'(last_fim), 34);
        checkOutput("slot3_uma_escrita", 32'(last_writes), 1);

        $display("[TB] all slots active moving south");
        fillAllSouth();
        loadTable();
        applyStimulus("todos", 0, 0);
        checkOutput("todos_fim", 32'(last_fim), 49);
        checkOutput("todos_queda", 32'(last_fall), 50);
        checkOutput("todos_escritas", 32'(last_writes), 16);
        checkOutput("todos_slot9", 32'(ram[9]), 32'h0C91);

        $display("[TB] border crossing on slot 0");
        for (int i = 0; i < N; i++) tbl[i] = '0;
        tbl[0] = 12'hF03;
        loadTable();
        applyStimulus("borda", 0, 0);
`ifdef ASTEROIDES_WRAP_EN
        checkOutput("borda_valor", 32'(ram[0]), 32'h0FF2);
`else
        checkOutput("borda_valor", 32'(ram[0]), 32'h0703);
        checkOutput("borda_saiu", 32'(last_saiu), 1);
`endif

        $display("[TB] second start pulse mid-walk");
        fillAllSouth();
        loadTable();
        applyStimulus("pulso_extra", 10, 0);
        checkOutput("pulso_extra_fim", 32'(last_fim), 49);
        checkOutput("pulso_extra_pulsos", 32'(last_fims), 1);

        $display("[TB] reset in cycle 20");
        fillAllSouth();
        loadTable();
        applyStimulus("reset_meio", 0, 20);
        checkOutput("reset_meio_slot5", 32'(ram[5]), 32'h0C51);
        checkOutput("reset_meio_slot6", 32'(ram[6]), 32'h0C60);
        applyStimulus("apos_reset", 0, 0);
        checkOutput("apos_reset_fim", 32'(last_fim), 49);
        checkOutput("apos_reset_slot5", 32'(ram[5]), 32'h0C52);

        $display("[TB] random tables");
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) tbl[i] = 12'($urandom_range(0, 4095));
            if (k == 0) begin
                tbl[0]  = 12'h900 | 12'($urandom_range(0, 255));
                tbl[15] = 12'h0FF;
            end
            loadTable();
            applyStimulus("aleatorio", (k % 2 == 1) ? int'($urandom_range(2, 30)) : 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uc_movimenta_asteroides.md
# uc_movimenta_asteroides

Control unit that walks the asteroid table in RAM once per movement request and advances every active asteroid by one grid step in its stored direction. It is started by the one-cycle `sinal_movimenta_asteroides` pulse from the asteroid/shot coordinator. It answers with a one-cycle `fim_move_asteroides` pulse. It is the sole owner of the asteroid RAM port while busy; the coordinator guarantees no other writer during that window.

## Interface
- `N_ASTEROIDES`, 16: number of table slots; power of two, at least 2.
- `ADDR_W`, 4: address width, equal to log2(N_ASTEROIDES).
- `COORD_W`, 4: width of each X/Y coordinate.
- Entry word: width W = 4 + 2·COORD_W, laid out as {ativo[1], dir[3], x[COORD_W], y[COORD_W]}, MSB first.

- `clock` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `sinal_movimenta_asteroides` in 1: start pulse; sampled only in OCIOSO.
- `mem_dado_lido` in W: RAM read data, valid the cycle after `mem_endereco` is presented (synchronous read).
- `mem_endereco` out ADDR_W: RAM address.
- `mem_escreve` out 1: RAM write enable.
- `mem_dado_escrito` out W: RAM write data.
- `ocupado` out 1: high in every state except OCIOSO.
- `asteroide_saiu` out 1: one-cycle pulse when an asteroid is deactivated at the border. Present only without wrap; see Configuration.
- `fim_move_asteroides` out 1: one-cycle completion pulse.
- `db_estado_movimenta_asteroides` out 3: encoded current state.

## Operation
- The FSM is Moore; all outputs decode from the state and the index register `idx` only.
- States and codes:
  - OCIOSO 0
  - LE 1
  - AVALIA 2
  - ESCREVE 3
  - FIM 4
  - Any illegal code reads back as 7 and goes to OCIOSO.
- OCIOSO:
  - `idx` = 0.
  - If `sinal_movimenta_asteroides` = 1, go to LE; otherwise stay.
- LE: `mem_endereco` = `idx`; go to AVALIA.
- AVALIA: `mem_endereco` = `idx`; capture `mem_dado_lido` into the entry register.
  - If `ativo` = 0 and `idx` = N-1, go to FIM.
  - If `ativo` = 0 and `idx` < N-1, increment `idx` and go to LE.
  - If `ativo` = 1, go to ESCREVE.
- ESCREVE: `mem_escreve` = 1, `mem_endereco` = `idx`, `mem_dado_escrito` = updated entry.
  - If `idx` = N-1, go to FIM; otherwise increment `idx` and go to LE.
- FIM: `fim_move_asteroides` = 1; go to OCIOSO.
- Direction codes, each one step:
  - 0 N (y-1)
  - 1 NE (x+1, y-1)
  - 2 E (x+1)
  - 3 SE (x+1, y+1)
  - 4 S (y+1)
  - 5 SW (x-1, y+1)
  - 6 W (x-1)
  - 7 NW (x-1, y-1)
- Arithmetic is COORD_W+1 bits wide. A result below 0 or above 2^COORD_W-1 on either axis is a border crossing.
- `dir` is written back unchanged. `ativo` is written back as 1 unless the border-crossing rule clears it.
- A start pulse while `ocupado` = 1 is ignored. It is neither queued nor does it restart the walk.

## Timing
- Reset values:
  - State = OCIOSO, `idx` = 0.
  - `mem_endereco` = 0, `mem_escreve` = 0, `mem_dado_escrito` = 0.
  - `ocupado` = 0, `asteroide_saiu` = 0, `fim_move_asteroides` = 0.
  - `db_estado_movimenta_asteroides` = 0.
- Start pulse sampled at edge 0: LE occupies cycle 1.
- Per-slot cost: active slot 3 cycles (LE, AVALIA, ESCREVE); inactive slot 2 cycles (LE, AVALIA).
- `fim_move_asteroides` is high in cycle 1 + 2·N + A, where A is the number of active slots. For N=16: all active, cycle 49; none active, cycle 33.
- At most one write per slot. Writes occur only in ESCREVE.
- Reset mid-walk: the FSM returns to OCIOSO immediately with no write or `fim` pulse. Slots already written keep their new values.

## Configuration
- `ASTEROIDES_WRAP_EN` defined:
  - A border crossing wraps modulo 2^COORD_W on the affected axis.
  - `ativo` stays 1.
  - The `asteroide_saiu` port does not exist.
- Not defined:
  - A border crossing writes the entry with `ativo` = 0 and coordinates unchanged.
  - `asteroide_saiu` pulses during that ESCREVE cycle.

## Structure
- Shared package `asteroides_pkg`:
  - State codes.
  - Direction codes.
  - Entry field offsets and widths.
  - W as a function of COORD_W.
- Sub-module `calc_posicao_asteroide`: combinational; takes the entry and produces the updated entry and a border-crossing flag. It holds the only copy of the direction decode.

## Test plan
- Single active slot 3: {1, dir 2, x=5, y=7}, all others inactive; pulse start. Slot 3 is written as {1, 2, 6, 7}, with exactly one write. `fim` arrives at cycle 34.
- All 16 slots active with dir 4 and y=0: every slot is written with y=1, giving 16 writes. `fim` arrives at cycle 49 and `ocupado` falls in cycle 50.
- Border crossing, slot 0 = {1, dir 7, x=0, y=3}:
  - Without the macro: written as {0, 7, 0, 3} and `asteroide_saiu` pulses once.
  - With the macro: written as {1, 7, 15, 2}.
- Second start pulse at cycle 10 of a walk: no restart. Exactly one `fim` pulse, at the nominal cycle.
- Reset asserted in cycle 20 of an all-active walk:
  - Outputs return to reset values asynchronously.
  - Slots 0–5 keep their updated values; slots 6–15 are untouched.
  - A new start completes normally.
